// File: rtl/regfile_wb_sched_pkg.sv
// Shared register-file configuration and writeback source encodings.
package regfile_wb_sched_pkg;

  localparam int unsigned RegAddrLen = 5;
  localparam int unsigned RegLen     = 32;
  localparam int unsigned RegNum     = 32;
  localparam logic [RegLen-1:0] ZeroWord = '0;

  typedef enum logic {
    WbSrcAlu = 1'b0,
    WbSrcMem = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_sched_wb_rr_arbiter.sv
// Two-requester round-robin arbiter for the shared register-file write port.
module wb_rr_arbiter
  import regfile_wb_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic grant_alu,
  output logic grant_mem
);

  wb_src_e rr_ptr;
  wb_src_e rr_ptr_next;

  always_comb begin
    grant_alu   = alu_valid && (!mem_valid || rr_ptr == WbSrcAlu);
    grant_mem   = mem_valid && (!alu_valid || rr_ptr == WbSrcMem);
    rr_ptr_next = rr_ptr;
    // Pointer only moves on contention, to the source that just lost.
    if (alu_valid && mem_valid) begin
      rr_ptr_next = (rr_ptr == WbSrcAlu) ? WbSrcMem : WbSrcAlu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= WbSrcMem;
    end else begin
      rr_ptr <= rr_ptr_next;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: ALU/MEM round-robin writeback plus
// per-register pending-write scoreboard driving the decode stall.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrLen,
  parameter int unsigned DATA_W     = RegLen
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_en,
  input  logic                  id_rs2_en,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_en,
  output logic                  id_stall,
  input  logic                  alu_wb_valid,
  input  logic [REG_ADDR_W-1:0] alu_wb_addr,
  input  logic [DATA_W-1:0]     alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  mem_wb_valid,
  input  logic [REG_ADDR_W-1:0] mem_wb_addr,
  input  logic [DATA_W-1:0]     mem_wb_data,
  output logic                  mem_wb_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  sched_err
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_W;

  logic [1:0] cnt      [NumRegs];
  logic [1:0] cnt_next [NumRegs];

  logic grant_alu, grant_mem;
  logic rs1_busy, rs2_busy, rd_full;
  logic issue;
  logic inc, dec;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_wb_valid),
    .mem_valid (mem_wb_valid),
    .grant_alu (grant_alu),
    .grant_mem (grant_mem)
  );

  assign alu_wb_ready = rst_n && grant_alu;
  assign mem_wb_ready = rst_n && grant_mem;

  // A register retiring this cycle is bypassed, so it counts one less.
  always_comb begin
    rs1_busy = id_rs1_en && (id_rs1 != '0) && (cnt[id_rs1] != 2'd0) &&
               !(rf_we && (rf_waddr == id_rs1) && (cnt[id_rs1] == 2'd1));
    rs2_busy = id_rs2_en && (id_rs2 != '0) && (cnt[id_rs2] != 2'd0) &&
               !(rf_we && (rf_waddr == id_rs2) && (cnt[id_rs2] == 2'd1));
    rd_full  = id_rd_en && (id_rd != '0) && (cnt[id_rd] == 2'd3) &&
               !(rf_we && (rf_waddr == id_rd));
    id_stall = rst_n && id_valid && (rs1_busy || rs2_busy || rd_full);
    issue    = id_valid && !id_stall;
  end

  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    cnt_next[0] = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      cnt_next[i] = cnt[i];
      inc = issue && id_rd_en && (id_rd == REG_ADDR_W'(i));
      dec = rf_we && (rf_waddr == REG_ADDR_W'(i)) && (cnt[i] != 2'd0);
      if (inc && !dec) begin
        cnt_next[i] = cnt[i] + 2'd1;
      end else if (dec && !inc) begin
        cnt_next[i] = cnt[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= DATA_W'(ZeroWord);
    end else if (grant_alu && (alu_wb_addr != '0)) begin
      rf_we    <= 1'b1;
      rf_waddr <= alu_wb_addr;
      rf_wdata <= alu_wb_data;
    end else if (grant_mem && (mem_wb_addr != '0)) begin
      rf_we    <= 1'b1;
      rf_waddr <= mem_wb_addr;
      rf_wdata <= mem_wb_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_err <= 1'b0;
    end else if (rf_we && (cnt[rf_waddr] == 2'd0)) begin
      sched_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: probe table plus scoreboarded writeback sequences.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_en, id_rs2_en, id_rd_en;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_stall;
  logic        alu_wb_valid, mem_wb_valid, alu_wb_ready, mem_wb_ready;
  logic [4:0]  alu_wb_addr, mem_wb_addr;
  logic [31:0] alu_wb_data, mem_wb_data;
  logic        rf_we, sched_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q [$];

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs1;
    logic       e1;
    logic [4:0] rs2;
    logic       e2;
    logic [4:0] rd;
    logic       rde;
    logic       av;
    logic       mv;
    logic       st;
    logic       ar;
    logic       mr;
  } vec_t;
  vec_t vecs [14];

  always #5 clk = ~clk;

  regfile_wb_sched #(.REG_ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_rd_en(id_rd_en), .id_stall(id_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr),
    .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr),
    .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sched_err(sched_err)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic e1,
                        input logic [4:0] r2, input logic e2,
                        input logic [4:0] rd, input logic rde);
    id_valid = v; id_rs1 = r1; id_rs1_en = e1;
    id_rs2 = r2; id_rs2_en = e2; id_rd = rd; id_rd_en = rde;
  endtask

  task automatic set_wb(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_wb_valid = av; alu_wb_addr = aa; alu_wb_data = ad;
    mem_wb_valid = mv; mem_wb_addr = ma; mem_wb_data = md;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Let combinational outputs settle and record any accepted non-zero writeback.
  task automatic settle();
    #1;
    if (alu_wb_ready && alu_wb_addr != 5'd0) exp_q.push_back({alu_wb_addr, alu_wb_data});
    if (mem_wb_ready && mem_wb_addr != 5'd0) exp_q.push_back({mem_wb_addr, mem_wb_data});
  endtask

  task automatic issue(input logic [4:0] rd);
    tick();
    idle();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1);
    settle();
    chk1("issue_no_stall", id_stall, 1'b0);
  endtask

  // Every accepted writeback must appear on the write port exactly one cycle later.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk1("rf_we", rf_we, 1'b1);
        chk32("rf_waddr", 32'(rf_waddr), 32'(e.addr));
        chk32("rf_wdata", rf_wdata, e.data);
      end else begin
        chk1("rf_we_idle", rf_we, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"raw_rs1",      1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{"raw_rs2",      1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{"rs1_unused",   1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{"rs1_free",     1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{"rd_overflow",  1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0};
    vecs[5]  = '{"rd_cnt1_ok",   1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{"rs1_zero",     1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{"not_valid",    0, 5, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{"rs2_rd7",      1, 3, 1, 7, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[9]  = '{"alu_alone",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    vecs[10] = '{"mem_alone",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    vecs[11] = '{"both_rr_mem",  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
    vecs[12] = '{"none",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{"stall_and_wb", 1, 5, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0};

    // Reset state, with traffic presented while reset is held.
    rst_n = 1'b0;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
    set_wb(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    #3;
    chk1("rst_rf_we", rf_we, 1'b0);
    chk32("rst_rf_waddr", 32'(rf_waddr), 32'h0);
    chk32("rst_rf_wdata", rf_wdata, 32'h0);
    chk1("rst_sched_err", sched_err, 1'b0);
    chk1("rst_id_stall", id_stall, 1'b0);
    chk1("rst_alu_ready", alu_wb_ready, 1'b0);
    chk1("rst_mem_ready", mem_wb_ready, 1'b0);
    tick(); tick();
    idle();
    rst_n = 1'b1;

    // RAW on r5 and same-cycle bypass release.
    issue(5'd5);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    settle();
    chk1("raw5_stall", id_stall, 1'b1);
    chk1("raw5_alu_ready", alu_wb_ready, 1'b1);
    tick();
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    chk1("raw5_bypass_no_stall", id_stall, 1'b0);
    tick();
    settle();
    chk1("raw5_after_no_stall", id_stall, 1'b0);

    // Build cnt[5]=1 and cnt[7]=3, then probe the combinational table.
    issue(5'd5);
    issue(5'd7);
    issue(5'd7);
    issue(5'd7);
    for (int i = 0; i < 14; i++) begin
      tick();
      set_id(vecs[i].v, vecs[i].rs1, vecs[i].e1, vecs[i].rs2, vecs[i].e2, vecs[i].rd, vecs[i].rde);
      set_wb(vecs[i].av, 5'd0, 32'h0, vecs[i].mv, 5'd0, 32'h0);
      #1;
      chk1({vecs[i].name, "_stall"}, id_stall, vecs[i].st);
      chk1({vecs[i].name, "_alu_ready"}, alu_wb_ready, vecs[i].ar);
      chk1({vecs[i].name, "_mem_ready"}, mem_wb_ready, vecs[i].mr);
      #1;
      idle();
    end

    // Overflow guard released in the cycle the write to r7 lands.
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    set_wb(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    settle();
    chk1("ovf_hold", id_stall, 1'b1);
    tick();
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    chk1("ovf_release", id_stall, 1'b0);
    tick();
    settle();
    chk1("ovf_full_again", id_stall, 1'b1);

    // Drain r7 (3) and r5 (1).
    for (int k = 0; k < 4; k++) begin
      tick();
      idle();
      if (k < 3) set_wb(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h700 + 32'(k));
      else       set_wb(1'b1, 5'd5, 32'h555, 1'b0, 5'd0, 32'h0);
      settle();
      chk1("drain_ready", (k < 3) ? mem_wb_ready : alu_wb_ready, 1'b1);
    end
    tick();
    idle();
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    settle();
    chk1("drained_no_stall", id_stall, 1'b0);

    // Contention: cnt[3]=cnt[4]=2, grants alternate starting with MEM.
    issue(5'd3);
    issue(5'd3);
    issue(5'd4);
    issue(5'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      idle();
      set_wb(1'b1, 5'd3, 32'hA0 + 32'(k), 1'b1, 5'd4, 32'hB0 + 32'(k));
      settle();
      chk1("rr_mem_grant", mem_wb_ready, (k % 2) == 0);
      chk1("rr_alu_grant", alu_wb_ready, (k % 2) == 1);
    end
    tick();
    idle();
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    settle();
    chk1("rr_counters_zero", id_stall, 1'b0);
    chk1("rr_no_err", sched_err, 1'b0);

    // Register 0: never pending, writeback accepted but not written.
    for (int k = 0; k < 4; k++) begin
      tick();
      idle();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
      if (k == 0) set_wb(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
      if (k == 1) set_wb(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5678);
      settle();
      chk1("r0_no_stall", id_stall, 1'b0);
      if (k == 0) chk1("r0_alu_ready", alu_wb_ready, 1'b1);
      if (k == 1) chk1("r0_mem_ready", mem_wb_ready, 1'b1);
    end

    // Writeback with zero pending count: write happens, error is sticky.
    tick();
    idle();
    set_wb(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    settle();
    chk1("err9_ready", mem_wb_ready, 1'b1);
    tick();
    idle();
    tick();
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    settle();
    chk1("err9_set", sched_err, 1'b1);
    chk1("err9_no_underflow", id_stall, 1'b0);
    tick();
    idle();
    tick();
    tick();
    #1;
    chk1("err9_sticky", sched_err, 1'b1);

    // Reset mid-stream with r12 pending and a write in flight.
    issue(5'd12);
    tick();
    set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b1, 5'd13, 32'h1313, 1'b1, 5'd14, 32'h1414);
    settle();
    chk1("pre_rst_stall", id_stall, 1'b1);
    chk1("pre_rst_mem_grant", mem_wb_ready, 1'b1);
    chk1("pre_rst_alu_lose", alu_wb_ready, 1'b0);
    @(posedge clk);
    #2;
    chk1("pre_rst_rf_we", rf_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async_rst_rf_we", rf_we, 1'b0);
    chk32("async_rst_waddr", 32'(rf_waddr), 32'h0);
    chk32("async_rst_wdata", rf_wdata, 32'h0);
    chk1("async_rst_err", sched_err, 1'b0);
    chk1("async_rst_stall", id_stall, 1'b0);
    chk1("async_rst_alu_ready", alu_wb_ready, 1'b0);
    chk1("async_rst_mem_ready", mem_wb_ready, 1'b0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121);
    settle();
    chk1("post_rst_no_stall", id_stall, 1'b0);
    chk1("post_rst_rr_mem", mem_wb_ready, 1'b1);
    chk1("post_rst_rr_alu", alu_wb_ready, 1'b0);
    tick();
    idle();
    tick();
    tick();
    chk32("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
